// File: rtl/clk_data_serializer.sv
// rtl/clk_data_serializer.sv - MSB-first parallel-to-serial converter with handshake input
// Optional trailing even-parity bit enabled by macro CLK_DATA_SERIALIZER_PARITY_EN.
module clk_data_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             data,
   output logic             sof,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

`ifdef CLK_DATA_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_nx;
   logic [WIDTH-2:0] rem, rem_nx;     // bits still to send; the head bit lives in data_q
   logic [CW-1:0]    cnt, cnt_nx;
   logic             data_q, data_nx;
   logic             sof_q, sof_nx;
   logic             last_bit;
   logic             ready_st;
   logic             accept;
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
   logic             par, par_nx;
`endif

   assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

`ifdef CLK_DATA_SERIALIZER_PARITY_EN
   assign ready_st = (state == IDLE) || (state == PARITY);
`else
   assign ready_st = (state == IDLE) || last_bit;
`endif

   // Ready is forced high while reset is held; reset still wins over any handshake.
   assign in_ready = ready_st | ~rst_n;
   assign accept   = in_valid & ready_st & rst_n;

   always_comb begin
      state_nx = state;
      rem_nx   = rem;
      cnt_nx   = cnt;
      data_nx  = 1'b0;
      sof_nx   = 1'b0;
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
      par_nx   = par;
`endif
      if (accept) begin
         state_nx = SHIFT;
         rem_nx   = in_data[WIDTH-2:0];
         cnt_nx   = '0;
         data_nx  = in_data[WIDTH-1];
         sof_nx   = 1'b1;
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
         par_nx   = ^in_data;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (last_bit) begin
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
                  state_nx = PARITY;
                  data_nx  = par;
`else
                  state_nx = IDLE;
`endif
               end else begin
                  data_nx = rem[WIDTH-2];
                  rem_nx  = rem << 1;
                  cnt_nx  = cnt + CW'(1);
               end
            end
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
            PARITY:  state_nx = IDLE;
`endif
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rem    <= '0;
         cnt    <= '0;
         data_q <= 1'b0;
         sof_q  <= 1'b0;
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
         par    <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         rem    <= rem_nx;
         cnt    <= cnt_nx;
         data_q <= data_nx;
         sof_q  <= sof_nx;
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
         par    <= par_nx;
`endif
      end
   end

   assign data = data_q;
   assign sof  = sof_q;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_clk_data_serializer.sv
// tb/tb_clk_data_serializer.sv - scoreboard bench for clk_data_serializer
// Expected {data,sof,busy,in_ready} per cycle are queued with the stimulus and popped after each edge.
module tb_clk_data_serializer;

   localparam int W = 8;
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
   localparam int SLOTS = W + 1;
`else
   localparam int SLOTS = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         data;
   logic         sof;
   logic         busy;

   typedef struct packed {
      logic d;
      logic s;
      logic b;
      logic r;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   clk_data_serializer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .data     (data),
      .sof      (sof),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed {d,sof,busy,rdy}=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic push_idle();
      exp_q.push_back('{d: 1'b0, s: 1'b0, b: 1'b0, r: 1'b1});
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int k = 0; k < W; k++) begin
         exp_q.push_back('{d: w[W-1-k], s: (k == 0), b: 1'b1, r: (k == SLOTS - 1)});
      end
`ifdef CLK_DATA_SERIALIZER_PARITY_EN
      exp_q.push_back('{d: ^w, s: 1'b0, b: 1'b1, r: 1'b1});
`endif
   endtask

   task automatic cyc(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, {data, sof, busy, in_ready}, e);
      end
   endtask

   initial begin
      // reset state
      push_idle();
      cyc("reset");
      push_idle();
      cyc("reset2");
      rst_n = 1'b1;

      // test 1: single word A5 from idle
      in_valid = 1'b1; in_data = 8'hA5;
      push_word(8'hA5);
      cyc("a5");
      in_valid = 1'b0; in_data = '0;
      repeat (SLOTS - 1) cyc("a5");
      push_idle();
      cyc("a5_idle");

      // test 2: back-to-back FF then 00 with in_valid held
      in_valid = 1'b1; in_data = 8'hFF;
      push_word(8'hFF);
      push_word(8'h00);
      cyc("ff");
      in_data = 8'h00;
      repeat (SLOTS - 1) cyc("ff");
      cyc("00");
      in_valid = 1'b0;
      repeat (SLOTS - 1) cyc("00");
      push_idle();
      cyc("b2b_idle");

      // test 3: in_valid pulse during the 3rd shift cycle is ignored
      in_valid = 1'b1; in_data = 8'h5A;
      push_word(8'h5A);
      cyc("5a");
      in_valid = 1'b0;
      cyc("5a");
      cyc("5a");
      in_valid = 1'b1; in_data = 8'h3C;
      cyc("5a_pulse");
      in_valid = 1'b0; in_data = '0;
      repeat (SLOTS - 4) cyc("5a");
      push_idle();
      cyc("5a_idle");
      push_idle();
      cyc("5a_idle2");

      // test 4: reset in the 5th shift cycle of C3 aborts the word
      in_valid = 1'b1; in_data = 8'hC3;
      push_word(8'hC3);
      cyc("c3");
      in_valid = 1'b0;
      repeat (4) cyc("c3");
      rst_n = 1'b0;
      #1;
      check("rdy_in_reset", {1'b0, 1'b0, 1'b0, in_ready}, 4'b0001);
      exp_q.delete();
      push_idle();
      cyc("c3_reset");
      rst_n = 1'b1;
      for (int i = 0; i < SLOTS; i++) push_idle();
      repeat (SLOTS) cyc("c3_aborted");

      // test 5: word 07 (parity bit of 1 when enabled)
      in_valid = 1'b1; in_data = 8'h07;
      push_word(8'h07);
      cyc("07");
      in_valid = 1'b0;
      repeat (SLOTS - 1) cyc("07");
      push_idle();
      cyc("07_idle");

      // test 6: handshake coinciding with reset is dropped
      in_valid = 1'b1; in_data = 8'h81; rst_n = 1'b0;
      push_idle();
      cyc("81_reset");
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (3) push_idle();
      repeat (3) cyc("81_dropped");

      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_data_serializer.md
CLK_DATA_SERIALIZER -- requirements
Module: clk_data_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port in_data  input  WIDTH  the parallel word to serialize.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  the block accepts a word this cycle.
REQ-007 SHALL have port data  output  1  serial bit stream; it is registered and drives the D input of the downstream capture flop.
REQ-008 SHALL have port sof  output  1  high during the first serial bit of each word.
REQ-009 SHALL have port busy  output  1  high while a word or its parity bit is on data.

Function
REQ-010 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, capturing in_data into an internal shift register.
REQ-011 SHALL ignore in_valid when in_ready=0; in_data SHALL NOT be captured and SHALL NOT be queued.
REQ-012 SHALL implement the states IDLE, SHIFT and PARITY (PARITY only when the REQ-024 macro is defined).
REQ-013 SHALL transition IDLE->SHIFT on acceptance; data SHALL show in_data[WIDTH-1] in the cycle after acceptance (latency 1), with sof=1 and busy=1.
REQ-014 SHALL shift MSB first, one bit per cycle, so bit WIDTH-1-k is on data in the k-th SHIFT cycle (k=0..WIDTH-1), with sof=0 for k>0.
REQ-015 SHALL count bits with a counter of ceil(log2(WIDTH)) bits; the counter SHALL clear on acceptance and never wrap within a word.
REQ-016 SHALL drive in_ready=1 in IDLE and in the final serial cycle of a word (the last data bit, or the parity bit when enabled); it SHALL be 0 otherwise.
REQ-017 SHALL stream back-to-back words: acceptance in the final serial cycle puts the new word's MSB on data in the next cycle, with sof=1 and no idle gap.
REQ-018 SHALL enter IDLE after the final serial cycle when no word is accepted; in IDLE data=0, sof=0 and busy=0.
REQ-019 SHALL make in_ready combinational from state only and never dependent on in_valid.

Reset
REQ-020 SHALL, while rst_n=0 at a rising edge, enter IDLE and clear the shift register and counter, giving data=0, sof=0, busy=0 and in_ready=1 in the following cycle.
REQ-021 SHALL abort any word in flight on reset, including a word in mid-SHIFT or PARITY; no further bits of that word SHALL appear.
REQ-022 SHALL give reset priority over a simultaneous in_valid/in_ready handshake; the offered word is dropped.
REQ-023 SHALL hold in_ready=1 during reset; handshakes on those edges are not honoured.

Configuration
REQ-024 SHALL, when macro CLK_DATA_SERIALIZER_PARITY_EN is defined, append one PARITY cycle after the LSB, driving data with the even parity (XOR) of the accepted word and busy=1.
REQ-025 SHALL, when CLK_DATA_SERIALIZER_PARITY_EN is undefined, omit the PARITY state, so a word occupies exactly WIDTH cycles.

Verification
REQ-026 SHALL pass test 1: WIDTH=8, accept 8'hA5 from IDLE -> data = 1,0,1,0,0,1,0,1 over the next 8 cycles, with sof only on the first of them and busy for all 8, then IDLE.
REQ-027 SHALL pass test 2: hold in_valid=1 with 8'hFF then 8'h00 -> 16 contiguous bits (8 ones then 8 zeros), sof in cycles 1 and 9, and no busy gap.
REQ-028 SHALL pass test 3: pulse in_valid with 8'h3C during the 3rd SHIFT cycle of a word -> the pulse is ignored and the in-flight word completes unchanged.
REQ-029 SHALL pass test 4: assert rst_n=0 in the 5th SHIFT cycle of 8'hC3 -> on the next cycle data=0, busy=0 and in_ready=1, and no remaining bits of 8'hC3 appear.
REQ-030 SHALL pass test 5: with the REQ-024 macro defined, send 8'h07 -> 8 data bits then a parity bit of 1 in the 9th cycle, in_ready=1 only in that 9th cycle.
REQ-031 SHALL pass test 6: in_valid=1 with 8'h81 and rst_n=0 on the same edge -> the word is dropped and data stays 0.
